// File: rtl/footsies_pkg.sv
// Shared player-state encodings and default frame-data lengths for the fighter
// FSM and the sprite renderer.
package footsies_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE         = 4'd0;
   localparam state_t ST_BACKWARD     = 4'd1;
   localparam state_t ST_FORWARD      = 4'd2;
   localparam state_t ST_ATK_START    = 4'd3;
   localparam state_t ST_ATK_ACTIVE   = 4'd4;
   localparam state_t ST_ATK_RECOVERY = 4'd5;
   localparam state_t ST_DIR_START    = 4'd6;
   localparam state_t ST_DIR_ACTIVE   = 4'd7;
   localparam state_t ST_DIR_RECOVERY = 4'd8;
   localparam state_t ST_HITSTUN      = 4'd9;
   localparam state_t ST_BLOCKSTUN    = 4'd10;

   localparam int ATK_START_DEF    = 5;
   localparam int ATK_ACTIVE_DEF   = 2;
   localparam int ATK_RECOVERY_DEF = 16;
   localparam int DIR_START_DEF    = 4;
   localparam int DIR_ACTIVE_DEF   = 3;
   localparam int DIR_RECOVERY_DEF = 15;
   localparam int HITSTUN_DEF      = 15;
   localparam int BLOCKSTUN_DEF    = 15;

   function automatic logic is_neutral(input state_t s);
      return (s <= ST_FORWARD);
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating 5-bit frames-in-state counter; load clears it, tick advances it.
// Single-cycle registered update; done compares the count against length-1.
module frame_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic       i_tick,
   input  logic [4:0] i_len,
   output logic [4:0] o_cnt,
   output logic       o_done
);

   logic [4:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 5'd0;
      end else if (i_load) begin
         r_cnt <= 5'd0;
      end else if (i_tick && (r_cnt != 5'd31)) begin
         r_cnt <= r_cnt + 5'd1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_done = (r_cnt == (i_len - 5'd1));

endmodule

// File: rtl/player_fsm.sv
// Per-player movement/attack/stun state machine, advanced once per video frame.
// Button edges and hits are latched between frames and consumed by the next frame_tick.
module player_fsm
   import footsies_pkg::*;
#(
   parameter int IS_MIRRORED  = 0,
   parameter int ATK_START    = ATK_START_DEF,
   parameter int ATK_ACTIVE   = ATK_ACTIVE_DEF,
   parameter int ATK_RECOVERY = ATK_RECOVERY_DEF,
   parameter int DIR_START    = DIR_START_DEF,
   parameter int DIR_ACTIVE   = DIR_ACTIVE_DEF,
   parameter int DIR_RECOVERY = DIR_RECOVERY_DEF,
   parameter int HITSTUN      = HITSTUN_DEF,
   parameter int BLOCKSTUN    = BLOCKSTUN_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_attack,
   input  logic       hit_in,
   output logic [3:0] state,
   output logic       atk_active,
   output logic [4:0] frame_cnt,
   output logic       state_changed
);

   logic       r_atk_prev;
   logic       r_atk_pend;
   logic       r_hit_pend;
   logic       r_state_changed;
   state_t     r_state;

   logic       w_atk;
   logic       w_hit;
   logic       w_fwd;
   logic       w_bwd;
   logic       w_invalid;
   logic       w_adv;
   logic       w_reenter;
   logic       w_load;
   logic       w_done;
   logic [4:0] w_len;
   logic [4:0] w_cnt;
   state_t     w_next;

   // Events arriving on the tick cycle itself are folded in and consumed by that tick.
   assign w_atk     = r_atk_pend | (btn_attack & ~r_atk_prev);
   assign w_hit     = r_hit_pend | hit_in;
   assign w_fwd     = (IS_MIRRORED != 0) ? btn_left  : btn_right;
   assign w_bwd     = (IS_MIRRORED != 0) ? btn_right : btn_left;
   assign w_invalid = (r_state > ST_BLOCKSTUN);
   assign w_adv     = frame_tick | w_invalid;

   always_comb begin
      w_len = 5'd1;
      case (r_state)
         ST_ATK_START:    w_len = 5'(ATK_START);
         ST_ATK_ACTIVE:   w_len = 5'(ATK_ACTIVE);
         ST_ATK_RECOVERY: w_len = 5'(ATK_RECOVERY);
         ST_DIR_START:    w_len = 5'(DIR_START);
         ST_DIR_ACTIVE:   w_len = 5'(DIR_ACTIVE);
         ST_DIR_RECOVERY: w_len = 5'(DIR_RECOVERY);
         ST_HITSTUN:      w_len = 5'(HITSTUN);
         ST_BLOCKSTUN:    w_len = 5'(BLOCKSTUN);
         default:         w_len = 5'd1;
      endcase
   end

   always_comb begin
      w_next    = r_state;
      w_reenter = 1'b0;
      if (w_invalid) begin
         w_next = ST_IDLE;
      end else if (is_neutral(r_state)) begin
         if (w_hit)                          w_next = (r_state == ST_BACKWARD) ? ST_BLOCKSTUN : ST_HITSTUN;
         else if (w_atk && (btn_left ^ btn_right)) w_next = ST_DIR_START;
         else if (w_atk)                     w_next = ST_ATK_START;
         else if (w_fwd && !w_bwd)           w_next = ST_FORWARD;
         else if (w_bwd && !w_fwd)           w_next = ST_BACKWARD;
         else                                w_next = ST_IDLE;
      end else if ((r_state == ST_HITSTUN) || (r_state == ST_BLOCKSTUN)) begin
         if (w_hit)       w_reenter = 1'b1;
         else if (w_done) w_next    = ST_IDLE;
      end else if (w_hit) begin
         w_next = ST_HITSTUN;
      end else if (w_done) begin
         case (r_state)
            ST_ATK_START:  w_next = ST_ATK_ACTIVE;
            ST_ATK_ACTIVE: w_next = ST_ATK_RECOVERY;
            ST_DIR_START:  w_next = ST_DIR_ACTIVE;
            ST_DIR_ACTIVE: w_next = ST_DIR_RECOVERY;
            default:       w_next = ST_IDLE;
         endcase
      end
   end

   // Staying in the same neutral state keeps counting; any real entry restarts at 0.
   assign w_load = w_adv & ((w_next != r_state) | w_reenter);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_state_changed <= 1'b0;
         r_atk_prev      <= 1'b0;
         r_atk_pend      <= 1'b0;
         r_hit_pend      <= 1'b0;
      end else begin
         if (w_adv) r_state <= w_next;
         r_state_changed <= w_load;
         r_atk_prev      <= btn_attack;
         r_atk_pend      <= frame_tick ? 1'b0 : w_atk;
         r_hit_pend      <= frame_tick ? 1'b0 : w_hit;
      end
   end

   frame_timer u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_tick (frame_tick),
      .i_len  (w_len),
      .o_cnt  (w_cnt),
      .o_done (w_done)
   );

   assign state         = r_state;
   assign frame_cnt     = w_cnt;
   assign state_changed = r_state_changed;
   assign atk_active    = (r_state == ST_ATK_ACTIVE) || (r_state == ST_DIR_ACTIVE);

endmodule
